// File: rtl/dash_pkg.sv
// rtl/dash_pkg.sv - shared defaults, colour constants and types for dash_render
package dash_pkg;
   localparam int DEF_CELL   = 24;
   localparam int DEF_GRID_W = 2;
   localparam int DEF_COLS   = 32;
   localparam int DEF_ROWS   = 6;
   localparam int PIPE_DEPTH = 3;

   localparam logic [4:0] R_ON = 5'd31;
   localparam logic [5:0] G_ON = 6'd63;
   localparam logic [4:0] B_ON = 5'd31;

   typedef struct packed {
      logic de;
      logic hsync;
      logic vsync;
   } sync_t;

   // Column c shows register bit 31-c; the lowest bit of each byte is marked.
   function automatic logic is_byte_tail(input int col);
      return ((31 - col) % 8) == 0;
   endfunction
endpackage

// File: rtl/dash_cell_cnt.sv
// rtl/dash_cell_cnt.sv - offset-within-cell / cell-index counter pair
module dash_cell_cnt
   import dash_pkg::*;
#(
   parameter int CELL = DEF_CELL,
   parameter int MAX  = DEF_COLS,
   localparam int OW  = $clog2(CELL),
   localparam int IW  = $clog2(MAX + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          adv_i,
   output logic [OW-1:0] off_o,
   output logic [IW-1:0] idx_o
);
   logic [OW-1:0] off_q, off_d, off_cur;
   logic [IW-1:0] idx_q, idx_d, idx_cur;

   // clr_i takes effect in the same cycle so the outputs describe the current pixel
   always_comb begin
      off_cur = clr_i ? '0 : off_q;
      idx_cur = clr_i ? '0 : idx_q;
      off_d   = off_cur;
      idx_d   = idx_cur;
      if (adv_i) begin
         if (off_cur == OW'(CELL - 1)) begin
            off_d = '0;
            if (idx_cur != IW'(MAX)) idx_d = idx_cur + 1'b1;
         end else begin
            off_d = off_cur + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         off_q <= '0;
         idx_q <= '0;
      end else begin
         off_q <= off_d;
         idx_q <= idx_d;
      end
   end

   assign off_o = off_cur;
   assign idx_o = idx_cur;
endmodule

// File: rtl/dash_render.sv
// rtl/dash_render.sv - register-bitmap dashboard overlay, 3-stage pipeline; DASH_SNAPSHOT_EN latches regs per frame
module dash_render
   import dash_pkg::*;
#(
   parameter int CELL   = DEF_CELL,
   parameter int GRID_W = DEF_GRID_W,
   parameter int COLS   = DEF_COLS,
   parameter int ROWS   = DEF_ROWS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               de,
   input  logic               hsync,
   input  logic               vsync,
   input  logic [ROWS*32-1:0] regs,
   output logic               lcd_de,
   output logic               lcd_hsync,
   output logic               lcd_vsync,
   output logic [4:0]         lcd_r,
   output logic [5:0]         lcd_g,
   output logic [4:0]         lcd_b
);
   localparam int OW = $clog2(CELL);
   localparam int CW = $clog2(COLS + 1);
   localparam int RW = $clog2(ROWS + 1);

   logic               de_q, armed_q, rise, fall;
   logic [OW-1:0]      x_off, y_off;
   logic [CW-1:0]      col;
   logic [RW-1:0]      row;
   logic [ROWS*32-1:0] src;

   // armed_q blocks a line already in progress when reset was released
   assign rise = de & ~de_q;
   assign fall = de_q & ~de & armed_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         de_q    <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         de_q    <= de;
         armed_q <= armed_q | ~de;
      end
   end

   dash_cell_cnt #(.CELL(CELL), .MAX(COLS)) u_x_cnt (
      .clk_i(clk), .rst_i(rst), .clr_i(rise), .adv_i(de), .off_o(x_off), .idx_o(col)
   );

   dash_cell_cnt #(.CELL(CELL), .MAX(ROWS)) u_y_cnt (
      .clk_i(clk), .rst_i(rst), .clr_i(vsync), .adv_i(fall & ~vsync), .off_o(y_off), .idx_o(row)
   );

`ifdef DASH_SNAPSHOT_EN
   logic               vs_q;
   logic [ROWS*32-1:0] snap_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         vs_q   <= 1'b0;
         snap_q <= '0;
      end else begin
         vs_q <= vsync;
         if (vsync & ~vs_q) snap_q <= regs;
      end
   end
   assign src = snap_q;
`else
   assign src = regs;
`endif

   sync_t         sync_q [PIPE_DEPTH];
   logic          s1_px_q;
   logic [OW-1:0] s1_x_q, s1_y_q;
   logic [CW-1:0] s1_col_q;
   logic [RW-1:0] s1_row_q;
   logic          s2_on_d, s2_bit_d, s2_tail_d, s2_on_q, s2_bit_q, s2_tail_q;
   logic [31:0]   word;
   logic [4:0]    r_d, r_q, b_d, b_q;
   logic [5:0]    g_d, g_q;

   always_comb begin
      word      = '0;
      s2_bit_d  = 1'b0;
      s2_tail_d = 1'b0;
      for (int r = 0; r < ROWS; r++)
         if (s1_row_q == RW'(r)) word = 32'(src >> (32 * r));
      for (int c = 0; c < COLS; c++)
         if (s1_col_q == CW'(c)) begin
            s2_bit_d  = |(word & (32'h8000_0000 >> c));
            s2_tail_d = is_byte_tail(c);
         end
      s2_on_d = s1_px_q && (s1_col_q < CW'(COLS)) && (s1_row_q < RW'(ROWS)) &&
                !((s1_x_q < OW'(GRID_W)) || (s1_y_q < OW'(GRID_W)));
   end

   always_comb begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
      if (s2_on_q) begin
         r_d = s2_bit_q ? R_ON : '0;
         g_d = s2_tail_q ? '0 : G_ON;
         b_d = B_ON;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PIPE_DEPTH; i++) sync_q[i] <= '0;
         s1_px_q   <= 1'b0;
         s1_x_q    <= '0;
         s1_y_q    <= '0;
         s1_col_q  <= '0;
         s1_row_q  <= '0;
         s2_on_q   <= 1'b0;
         s2_bit_q  <= 1'b0;
         s2_tail_q <= 1'b0;
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
      end else begin
         sync_q[0] <= '{de: de, hsync: hsync, vsync: vsync};
         for (int i = 1; i < PIPE_DEPTH; i++) sync_q[i] <= sync_q[i-1];
         s1_px_q   <= de & armed_q;
         s1_x_q    <= x_off;
         s1_y_q    <= y_off;
         s1_col_q  <= col;
         s1_row_q  <= row;
         s2_on_q   <= s2_on_d;
         s2_bit_q  <= s2_bit_d;
         s2_tail_q <= s2_tail_d;
         r_q       <= r_d;
         g_q       <= g_d;
         b_q       <= b_d;
      end
   end

   assign lcd_de    = sync_q[PIPE_DEPTH-1].de;
   assign lcd_hsync = sync_q[PIPE_DEPTH-1].hsync;
   assign lcd_vsync = sync_q[PIPE_DEPTH-1].vsync;
   assign lcd_r     = r_q;
   assign lcd_g     = g_q;
   assign lcd_b     = b_q;
endmodule

// File: tb/tb_dash_render.sv
// tb/tb_dash_render.sv - self-checking bench for dash_render; honours DASH_SNAPSHOT_EN
module tb_dash_render;
   import dash_pkg::*;

   localparam int CELL = DEF_CELL, GRID_W = DEF_GRID_W, COLS = DEF_COLS, ROWS = DEF_ROWS;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst = 1'b1, de = 1'b0, hsync = 1'b0, vsync = 1'b0;
   logic [ROWS*32-1:0] regs = '0;
   logic               lcd_de, lcd_hsync, lcd_vsync;
   logic [4:0]         lcd_r, lcd_b;
   logic [5:0]         lcd_g;

   dash_render dut (
      .clk(clk), .rst(rst), .de(de), .hsync(hsync), .vsync(vsync), .regs(regs),
      .lcd_de(lcd_de), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync),
      .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b)
   );

   typedef struct {
      logic [2:0]  sync;
      logic [15:0] rgb;
      int          px;
      int          py;
      bit          pix;
   } exp_t;

   exp_t               pipe [3];
   int                 vectors = 0, miscompares = 0;
   int                 mx = 0, my = 0;
   bit                 pde = 0, pvs = 0, seen_low = 0, line_ok = 0;
   logic [ROWS*32-1:0] snap = '0;
   int                 obs [int];

   function automatic logic [15:0] ref_rgb(input int x, input int y, input logic [ROWS*32-1:0] img);
      int col, row;
      logic b;
      if (x >= COLS * CELL || y >= ROWS * CELL) return 16'd0;
      if ((x % CELL) < GRID_W || (y % CELL) < GRID_W) return 16'd0;
      col = x / CELL;
      row = y / CELL;
      b = img[32 * row + 31 - col];
      return {(b ? 5'd31 : 5'd0), (((31 - col) % 8 == 0) ? 6'd0 : 6'd63), 5'd31};
   endfunction

   function automatic int llen(input int y);
      if (y == 10 || y == 30 || y == 143 || y == 144) return 800;
      return $urandom_range(120, 40);
   endfunction

   task automatic cyc(input bit r, input bit d, input bit h, input bit v);
      exp_t e, z;
      logic [ROWS*32-1:0] img;
      rst = r; de = d; hsync = h; vsync = v;
      z = '{sync: 3'b0, rgb: 16'd0, px: 0, py: 0, pix: 1'b0};
      e = z;
      e.sync = {d, h, v};
      if (r) begin
         mx = 0; my = 0; pde = 0; pvs = 0; seen_low = 0; line_ok = 0; snap = '0;
      end else begin
         if (d && !pde) begin
            if (seen_low) line_ok = 1;
            mx = 0;
         end else if (d) mx++;
`ifdef DASH_SNAPSHOT_EN
         img = snap;
`else
         img = regs;
`endif
         if (d && line_ok) begin
            e.pix = 1; e.px = mx; e.py = my;
            e.rgb = ref_rgb(mx, my, img);
         end
         if (v) my = 0;
         else if (!d && pde && line_ok) my++;
         if (!d) begin
            line_ok = 0;
            seen_low = 1;
         end
         if (v && !pvs) snap = regs;
         pde = d; pvs = v;
      end
      @(posedge clk);
      if (r) begin
         pipe[0] = z; pipe[1] = z; pipe[2] = z;
      end else begin
         pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = e;
      end
      @(negedge clk);
      vectors++;
      assert ({lcd_de, lcd_hsync, lcd_vsync, lcd_r, lcd_g, lcd_b} === {pipe[2].sync, pipe[2].rgb}) else begin
         miscompares++;
         $error("FAIL pixel x=%0d y=%0d observed=%h expected=%h", pipe[2].px, pipe[2].py,
                {lcd_de, lcd_hsync, lcd_vsync, lcd_r, lcd_g, lcd_b}, {pipe[2].sync, pipe[2].rgb});
      end
      if (pipe[2].pix) obs[pipe[2].py * 1024 + pipe[2].px] = int'({lcd_r, lcd_g, lcd_b});
   endtask

   task automatic line(input int len, input int nb);
      for (int i = 0; i < len; i++) cyc(0, 1, 1'($urandom_range(1, 0)), 0);
      for (int i = 0; i < nb; i++) cyc(0, 0, (i >= 1 && i < 3), 0);
   endtask

   task automatic vpulse();
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, (i >= 2 && i < 4));
   endtask

   task automatic probe(input string tag, input int x, input int y,
                        input logic [4:0] er, input logic [5:0] eg, input logic [4:0] eb);
      int got;
      got = obs.exists(y * 1024 + x) ? obs[y * 1024 + x] : -1;
      vectors++;
      assert (got === int'({er, eg, eb})) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, got, {er, eg, eb});
      end
   endtask

   logic [ROWS*32-1:0] r1;
   logic               exp_bit;
   int                 n, bad;

   initial begin
      pipe[0] = '{sync: 3'b0, rgb: 16'd0, px: 0, py: 0, pix: 1'b0};
      pipe[1] = pipe[0];
      pipe[2] = pipe[0];

      // reset with de toggling: every output must read zero
      for (int i = 0; i < 4; i++) begin
         cyc(1, i[0], 1, 1);
         vectors++;
         assert ({lcd_de, lcd_hsync, lcd_vsync, lcd_r, lcd_g, lcd_b} === 19'd0) else begin
            miscompares++;
            $error("FAIL reset_outputs observed=%h expected=0", {lcd_de, lcd_hsync, lcd_vsync, lcd_r, lcd_g, lcd_b});
         end
      end

      // first de after release reaches lcd_de three cycles later
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      n = 1;
      while (!lcd_de && n < 10) begin
         cyc(0, 1, 0, 0);
         n++;
      end
      vectors++;
      assert (n === 3) else begin
         miscompares++;
         $error("FAIL first_latency observed=%0d expected=3", n);
      end
      line(40 - n, 8);

      // bit map, grid, byte tail and bounds
      regs = '0;
      regs[31:0] = 32'h8000_0001;
      obs.delete();
      vpulse();
      for (int y = 0; y < 150; y++) line(llen(y), 8);
      probe("bit31_col0",   10,  10, 5'd31, 6'd63, 5'd31);
      probe("bit30_a",      30,  10, 5'd0,  6'd63, 5'd31);
      probe("bit30_b",      36,  10, 5'd0,  6'd63, 5'd31);
      probe("bit0_col31",   750, 10, 5'd31, 6'd0,  5'd31);
      probe("right_of_map", 770, 10, 5'd0,  6'd0,  5'd0);
      probe("grid_x",       24,  30, 5'd0,  6'd0,  5'd0);
      probe("grid_y",       30,  24, 5'd0,  6'd0,  5'd0);
      probe("byte_tail",    178, 30, 5'd0,  6'd0,  5'd31);
      probe("last_pixel",   767, 143, 5'd0, 6'd0,  5'd31);
      probe("col_bound",    768, 10, 5'd0,  6'd0,  5'd0);
      probe("row_bound",    10,  144, 5'd0, 6'd0,  5'd0);

      // registers change mid-frame at y=50
      for (int k = 0; k < ROWS; k++) r1[32*k +: 32] = $urandom;
      regs = r1;
      obs.delete();
      vpulse();
      for (int y = 0; y < 70; y++) begin
         if (y == 50) regs = ~r1;
         line(llen(y), 8);
      end
`ifdef DASH_SNAPSHOT_EN
      exp_bit = r1[95];
`else
      exp_bit = ~r1[95];
`endif
      probe("before_change", 10, 40, (r1[63] ? 5'd31 : 5'd0), 6'd63, 5'd31);
      probe("after_change",  10, 60, (exp_bit ? 5'd31 : 5'd0), 6'd63, 5'd31);

      // vsync in the same cycle as the de falling edge
      regs[31] = 1'b1;
      obs.delete();
      vpulse();
      for (int y = 0; y < 4; y++) line(50, 8);
      for (int i = 0; i < 50; i++) cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0);
      for (int y = 0; y < 4; y++) line(50, 8);
      probe("vs_fall_y1", 10, 1, 5'd0,  6'd0,  5'd0);
      probe("vs_fall_y2", 10, 2, 5'd31, 6'd63, 5'd31);

      // reset in the middle of a line, de still high at release
      vpulse();
      line(60, 8);
      for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(0, 1, 0, 0);
         if ({lcd_r, lcd_g, lcd_b} != 16'd0) bad++;
      end
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 0, 0);
         if ({lcd_r, lcd_g, lcd_b} != 16'd0) bad++;
      end
      vectors++;
      assert (bad === 0) else begin
         miscompares++;
         $error("FAIL partial_line_colour observed=%0d expected=0", bad);
      end
      obs.delete();
      for (int y = 0; y < 3; y++) line(50, 8);
      probe("post_reset_y1", 10, 1, 5'd0,  6'd0,  5'd0);
      probe("post_reset_y2", 10, 2, 5'd31, 6'd63, 5'd31);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
